hamming15_syndrome_stage: RTL and testbench
===========================================

Name: hamming15_syndrome_stage

Overview:
- Two-stage pipelined syndrome/error-locator for the Hamming(15,11) pipelined decoder.
- Accepts a 15-bit received word, computes its 4-bit syndrome, and decodes the syndrome into a one-hot 15-bit error mask.
- Presents the mask together with the aligned received word to the downstream 15-bit XOR correction stage, which computes out = word ^ mask.
- Valid/ready handshake on both sides, full backpressure support.

Parameters:
- N, 15, codeword width; fixed for Hamming(15,11); other values unsupported.
- S, 4, syndrome width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_word is valid this cycle.
- in_ready  output  1  stage can accept in_word this cycle.
- in_word  input  15  received codeword, bit k = code position k+1.
- out_valid  output  1  out_word/out_mask/out_syndrome are valid.
- out_ready  input  1  downstream XOR stage consumes this cycle.
- out_word  output  15  received word delayed and aligned with mask.
- out_mask  output  15  one-hot error mask, or zero.
- out_syndrome  output  4  syndrome of out_word.
- err_count  output  16  count of nonzero syndromes (see Optional Feature).

Behaviour:
- Reset, synchronous, sampled while rst_n=0 at a clk edge:
  - both stage valids := 0; all data registers := 0.
  - out_valid=0, out_word=0, out_mask=0, out_syndrome=0, err_count=0.
  - in_ready=1 in the first cycle after reset release.
- Reset mid-operation: in-flight words are discarded, no partial output.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Stage 1 (register v1, w1, s1):
  - s1 = XOR over all k with in_word[k]=1 of the 4-bit value (k+1).
  - w1 = in_word.
- Stage 2 (register v2, w2, s2, m2):
  - w2 = w1, s2 = s1.
  - m2 = 0 if s1=0, otherwise one-hot with bit (s1-1) set.
  - Outputs driven directly from stage-2 registers.
- Latency: 2 cycles from input transfer to out_valid when unstalled; throughput 1 word/cycle.
- Flow control, per-stage enable:
  - en2 = !v2 | out_ready.
  - en1 = !v1 | en2.
  - in_ready = en1, combinational; in_ready must not depend on in_valid.
- Stage 2 load: when en2, v2 := v1 and data := stage-1 data.
- Stage 1 load: when en1, v1 := input transfer and data := in_word/new syndrome.
- Hold: data registers hold whenever their stage enable is 0; out_* stay stable while out_valid & !out_ready.
- Simultaneous input and output transfer on a full pipe: both stages shift, no bubble, no loss.
- Empty pipe: out_valid=0; out_mask is don't-care but holds its last value.
- Double-bit errors: produce a nonzero syndrome and a single (wrong) mask bit, by design of SEC Hamming; no detection flag.
- Data registers need not clear when valid drops.

Optional Feature:
- Macro: HAMMING_ERR_COUNT_EN.
- Defined:
  - err_count increments by 1 on every output transfer with out_syndrome != 0.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: err_count is tied to 16'h0000 and no counter logic is generated.
- Port list is identical in both builds.

Test Plan:
- Reset, then in_word=15'h0000, out_ready=1 -> 2 cycles later out_valid=1, out_syndrome=0, out_mask=15'h0000, out_word=15'h0000.
- in_word=15'h0007 (positions 1^2^3=0) -> out_syndrome=0, out_mask=15'h0000; err_count unchanged.
- Back-to-back in_word 15'h0001, 15'h0004, 15'h4000 with out_ready=1:
  - out_syndrome 1, 3, 15 and out_mask 15'h0001, 15'h0004, 15'h4000 on consecutive cycles.
  - with macro defined, err_count=3.
- Backpressure: stream 4 words 15'h0010..15'h0013 while out_ready=0 for 4 cycles:
  - in_ready drops after 2 accepted words.
  - out_* stable at the first word.
  - after out_ready=1, all 4 emerge in order, none lost or duplicated.
- Reset mid-operation: rst_n=0 for 1 cycle with both stages valid -> next cycle out_valid=0, err_count=0, in_ready=1.
- Saturation (macro defined): force 65537 nonzero-syndrome transfers -> err_count stays 16'hFFFF. Macro undefined -> err_count=0 throughout.

Source files
------------

// File: rtl/hamming15_syndrome_stage.sv
// Two-stage syndrome / error-locator pipeline for the Hamming(15,11) decoder.
// Define HAMMING_ERR_COUNT_EN to build the saturating nonzero-syndrome counter on err_count.
module hamming15_syndrome_stage #(
   parameter int N = 15,
   parameter int S = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_word,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_word,
   output logic [N-1:0] out_mask,
   output logic [S-1:0] out_syndrome,
   output logic [15:0]  err_count
);

   // Syndrome is the XOR of the 1-based positions of every set bit.
   function automatic logic [S-1:0] calc_syndrome(input logic [N-1:0] w);
      logic [S-1:0] s;
      s = '0;
      for (int k = 0; k < N; k++) begin
         if (w[k]) s = s ^ S'(k + 1);
      end
      return s;
   endfunction

   function automatic logic [N-1:0] decode_mask(input logic [S-1:0] s);
      logic [N-1:0] m;
      m = '0;
      for (int k = 0; k < N; k++) begin
         if (s == S'(k + 1)) m[k] = 1'b1;
      end
      return m;
   endfunction

   logic         v1;
   logic [N-1:0] w1;
   logic [S-1:0] s1;
   logic         v2;
   logic [N-1:0] w2;
   logic [S-1:0] s2;
   logic [N-1:0] m2;
   logic         en1;
   logic         en2;
   logic [S-1:0] syn_in;
   logic [N-1:0] mask_next;

   assign en2       = !v2 | out_ready;
   assign en1       = !v1 | en2;
   assign in_ready  = en1;
   assign syn_in    = calc_syndrome(in_word);
   assign mask_next = decode_mask(s1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         w1 <= '0;
         s1 <= '0;
      end else if (en1) begin
         v1 <= in_valid;
         w1 <= in_word;
         s1 <= syn_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v2 <= 1'b0;
         w2 <= '0;
         s2 <= '0;
         m2 <= '0;
      end else if (en2) begin
         v2 <= v1;
         w2 <= w1;
         s2 <= s1;
         m2 <= mask_next;
      end
   end

   assign out_valid    = v2;
   assign out_word     = w2;
   assign out_syndrome = s2;
   assign out_mask     = m2;

`ifdef HAMMING_ERR_COUNT_EN
   logic [15:0] err_q;

   // Counts only words actually handed downstream, so stalled words are not recounted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= '0;
      end else if (v2 && out_ready && (s2 != '0) && (err_q != 16'hFFFF)) begin
         err_q <= err_q + 16'd1;
      end
   end

   assign err_count = err_q;
`else
   assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hamming15_syndrome_stage.sv
// Self-checking bench for hamming15_syndrome_stage: directed literal cases plus
// randomized traffic checked every cycle against an in-order scoreboard model.
module tb_hamming15_syndrome_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [14:0] in_word;
   logic        out_valid;
   logic        out_ready;
   logic [14:0] out_word;
   logic [14:0] out_mask;
   logic [3:0]  out_syndrome;
   logic [15:0] err_count;

   always #5 clk = ~clk;

   hamming15_syndrome_stage dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_word(in_word),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_word(out_word),
      .out_mask(out_mask),
      .out_syndrome(out_syndrome),
      .err_count(err_count)
   );

   typedef struct {
      logic [14:0] word;
      int          acc;
   } entry_t;

   entry_t      q[$];
   int          edgeCount = 0;
   int          checks = 0;
   int          failures = 0;
   logic [15:0] errModel = 16'h0;

   // Position (1..15) that a single flipped bit would have to sit at to explain the word.
   function automatic logic [3:0] positionXor(input logic [14:0] w);
      logic [3:0] r;
      r = 4'h0;
      for (int p = 1; p <= 15; p++) begin
         if (w[p-1]) r = r ^ 4'(p);
      end
      return r;
   endfunction

   function automatic logic [14:0] flipMask(input logic [3:0] syn);
      logic [14:0] m;
      m = '0;
      if (syn != 4'h0) m[int'(syn) - 1] = 1'b1;
      return m;
   endfunction

   function automatic logic modelValid();
      return (q.size() > 0) && (q[0].acc < edgeCount);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic checkOutput();
      logic expValid;
      logic expReady;
      expValid = modelValid();
      expReady = (q.size() < 2) || out_ready;
      check("in_ready", 32'(in_ready), 32'(expReady));
      check("out_valid", 32'(out_valid), 32'(expValid));
      if (expValid) begin
         check("out_word", 32'(out_word), 32'(q[0].word));
         check("out_syndrome", 32'(out_syndrome), 32'(positionXor(q[0].word)));
         check("out_mask", 32'(out_mask), 32'(flipMask(positionXor(q[0].word))));
      end
      check("err_count", 32'(err_count), 32'(errModel));
   endtask

   // Drives one cycle of inputs, advances the model across the edge, then checks.
   task automatic applyStimulus(input logic v, input logic [14:0] w, input logic r,
                                output logic acc, output logic emit, output logic [14:0] emitWord);
      logic expValid;
      logic inX;
      logic outX;
      in_valid  = v;
      in_word   = w;
      out_ready = r;
      #1;
      acc      = in_valid && in_ready;
      emit     = out_valid && out_ready;
      emitWord = out_word;
      if (!rst_n) begin
         q.delete();
         errModel = 16'h0;
      end else begin
         expValid = modelValid();
         outX     = expValid && out_ready;
         inX      = in_valid && ((q.size() < 2) || out_ready);
         if (outX) begin
`ifdef HAMMING_ERR_COUNT_EN
            if (positionXor(q[0].word) != 4'h0 && errModel != 16'hFFFF) errModel = errModel + 16'd1;
`endif
            void'(q.pop_front());
         end
         if (inX) q.push_back('{word: w, acc: edgeCount + 1});
      end
      @(posedge clk);
      edgeCount++;
      @(negedge clk);
      checkOutput();
   endtask

   task automatic doReset();
      logic a, e;
      logic [14:0] ew;
      rst_n = 1'b0;
      applyStimulus(1'b0, 15'h0, 1'b0, a, e, ew);
      rst_n = 1'b1;
   endtask

   initial begin
      logic        a, e;
      logic [14:0] ew;
      int          accepted;
      int          sent;
      logic [14:0] got[$];
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_word   = 15'h0;
      out_ready = 1'b0;
      @(negedge clk);
      doReset();
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_word", 32'(out_word), 32'h0);
      check("rst_out_mask", 32'(out_mask), 32'h0);
      check("rst_out_syndrome", 32'(out_syndrome), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h1);

      // All-zero word and a zero-syndrome word (positions 1^2^3).
      applyStimulus(1'b1, 15'h0000, 1'b1, a, e, ew);
      applyStimulus(1'b1, 15'h0007, 1'b1, a, e, ew);
      check("lit_zero_valid", 32'(out_valid), 32'h1);
      check("lit_zero_syn", 32'(out_syndrome), 32'h0);
      check("lit_zero_mask", 32'(out_mask), 32'h0);
      applyStimulus(1'b0, 15'h0, 1'b1, a, e, ew);
      check("lit_7_word", 32'(out_word), 32'h0007);
      check("lit_7_syn", 32'(out_syndrome), 32'h0);
      check("lit_7_mask", 32'(out_mask), 32'h0);
      check("lit_7_err", 32'(err_count), 32'h0);

      // Back-to-back single-bit errors.
      doReset();
      applyStimulus(1'b1, 15'h0001, 1'b1, a, e, ew);
      applyStimulus(1'b1, 15'h0004, 1'b1, a, e, ew);
      check("lit_b1_syn", 32'(out_syndrome), 32'h1);
      check("lit_b1_mask", 32'(out_mask), 32'h0001);
      applyStimulus(1'b1, 15'h4000, 1'b1, a, e, ew);
      check("lit_b2_syn", 32'(out_syndrome), 32'h3);
      check("lit_b2_mask", 32'(out_mask), 32'h0004);
      applyStimulus(1'b0, 15'h0, 1'b1, a, e, ew);
      check("lit_b3_syn", 32'(out_syndrome), 32'hF);
      check("lit_b3_mask", 32'(out_mask), 32'h4000);
      applyStimulus(1'b0, 15'h0, 1'b1, a, e, ew);
`ifdef HAMMING_ERR_COUNT_EN
      check("lit_b_err", 32'(err_count), 32'h3);
`else
      check("lit_b_err", 32'(err_count), 32'h0);
`endif

      // Backpressure: only two words fit while downstream is stalled.
      doReset();
      accepted = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 15'h0010 + 15'(accepted), 1'b0, a, e, ew);
         if (a) accepted++;
      end
      check("bp_accepted", 32'(accepted), 32'h2);
      check("bp_in_ready", 32'(in_ready), 32'h0);
      check("bp_head_word", 32'(out_word), 32'h0010);
      sent = accepted;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(sent < 4, 15'h0010 + 15'(sent), 1'b1, a, e, ew);
         if (a) sent++;
         if (e) got.push_back(ew);
      end
      check("bp_out_count", 32'(got.size()), 32'h4);
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         check("bp_order", 32'(got[i]), 32'h10 + 32'(i));
      end

      // Reset with both stages full.
      applyStimulus(1'b1, 15'h0123, 1'b0, a, e, ew);
      applyStimulus(1'b1, 15'h0456, 1'b0, a, e, ew);
      check("mid_full_valid", 32'(out_valid), 32'h1);
      doReset();
      check("mid_out_valid", 32'(out_valid), 32'h0);
      check("mid_err", 32'(err_count), 32'h0);
      check("mid_in_ready", 32'(in_ready), 32'h1);

      // Randomized traffic, with some single-bit-error words.
      for (int i = 0; i < 3000; i++) begin
         logic [14:0] w;
         w = 15'($urandom);
         if ($urandom_range(0, 3) == 0) w = 15'h1 << $urandom_range(0, 14);
         applyStimulus($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0, a, e, ew);
      end

`ifdef HAMMING_ERR_COUNT_EN
      doReset();
      for (int i = 0; i < 65540; i++) begin
         applyStimulus(1'b1, 15'h0001, 1'b1, a, e, ew);
      end
      check("sat_err", 32'(err_count), 32'hFFFF);
`else
      doReset();
      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'b1, 15'h0001, 1'b1, a, e, ew);
      end
      check("nocount_err", 32'(err_count), 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
